pc_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 28 ++
 rtl/pc_sequencer_next_pc_mux.sv | 51 +++++
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// ----------------------------------------------------------------------------
// pc_seq_pkg : shared types and constants for the PC / fetch sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } pcSeqState_t;

  typedef enum logic [1:0] {
    SEL_PC4 = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } nextPcSel_t;

  localparam logic [31:0] c_resetVector = 32'h0040_0000;
  localparam logic [5:0]  c_functJr     = 6'h08;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_next_pc_mux.sv
// ----------------------------------------------------------------------------
// next_pc_mux : priority select of the next PC (JR > Jump > taken branch > +4)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module next_pc_mux
  import pc_seq_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic [NBITS-1:0] pcPlus4,
  input  logic [25:0]      instrIndex,
  input  logic [NBITS-1:0] signExtImm,
  input  logic [NBITS-1:0] regRs,
  input  logic             branchEq,
  input  logic             branchNe,
  input  logic             jump,
  input  logic             jr,
  input  logic             zero,
  output logic [NBITS-1:0] nextPc,
  output nextPcSel_t       nextSel
);

  logic [NBITS-1:0] w_branchTarget;
  logic [NBITS-1:0] w_jumpTarget;
  logic             w_branchTaken;

  assign w_branchTarget = pcPlus4 + (signExtImm << 2);
  assign w_jumpTarget   = {pcPlus4[NBITS-1:28], instrIndex, 2'b00};
  // BEQ and BNE conditions are mutually exclusive on Zero, so OR-ing is safe
  assign w_branchTaken  = (branchEq & zero) | (branchNe & ~zero);

  always_comb begin
    nextSel = SEL_PC4;
    nextPc  = pcPlus4;
    if (jr) begin
      nextSel = SEL_JR;
      nextPc  = regRs;
    end else if (jump) begin
      nextSel = SEL_J;
      nextPc  = w_jumpTarget;
    end else if (w_branchTaken) begin
      nextSel = SEL_BR;
      nextPc  = w_branchTarget;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer : PC register, imem req/ack fetch FSM and next-PC update.
// Optional misaligned-target trap: PC_SEQ_MISALIGN_TRAP_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               NBITS        = 32,
  parameter logic [NBITS-1:0] RESET_VECTOR = NBITS'(c_resetVector)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [NBITS-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instruction,
  output logic             instr_valid,
  output logic [NBITS-1:0] PC,
  output logic [NBITS-1:0] PC_plus4,
  input  logic             BranchEQ,
  input  logic             BranchNE,
  input  logic             Jump,
  input  logic             Jal,
  input  logic             JR,
  input  logic             Zero,
  input  logic [NBITS-1:0] SignExtImm,
  input  logic [NBITS-1:0] RegRs,
  input  logic             stall,
  output logic             misalign_err
);

  pcSeqState_t      r_state;
  logic [NBITS-1:0] r_pc;
  logic [31:0]      r_instruction;
  logic             r_imemReq;
  logic             r_instrValid;
  logic [NBITS-1:0] w_nextPc;
  nextPcSel_t       w_nextSel;

  assign PC_plus4    = r_pc + NBITS'(4);
  assign PC          = r_pc;
  assign imem_addr   = r_pc;
  assign imem_req    = r_imemReq;
  assign Instruction = r_instruction;
  assign instr_valid = r_instrValid;

  next_pc_mux #(.NBITS(NBITS)) u_nextPcMux (
    .pcPlus4   (PC_plus4),
    .instrIndex(r_instruction[25:0]),
    .signExtImm(SignExtImm),
    .regRs     (RegRs),
    .branchEq  (BranchEQ),
    .branchNe  (BranchNE),
    .jump      (Jump),
    .jr        (JR),
    .zero      (Zero),
    .nextPc    (w_nextPc),
    .nextSel   (w_nextSel)
  );

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic r_misalignErr;
  assign misalign_err = r_misalignErr;
  logic w_unused;
  assign w_unused = ^{Jal, w_nextSel};
`else
  assign misalign_err = 1'b0;
  logic w_unused;
  assign w_unused = ^{Jal, w_nextSel, w_nextPc[1:0]};
`endif

  // req/valid are registered alongside the state so they track it exactly
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_VECTOR;
      r_instruction <= '0;
      r_imemReq     <= 1'b0;
      r_instrValid  <= 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      r_misalignErr <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_state   <= FETCH;
          r_imemReq <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            r_instruction <= imem_rdata;
            r_state       <= EXEC;
            r_imemReq     <= 1'b0;
            r_instrValid  <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            r_instrValid <= 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            if (w_nextPc[1:0] != 2'b00) begin
              r_misalignErr <= 1'b1;
              r_state       <= HALT;
              r_imemReq     <= 1'b0;
            end else begin
              r_pc      <= w_nextPc;
              r_state   <= FETCH;
              r_imemReq <= 1'b1;
            end
`else
            r_pc      <= {w_nextPc[NBITS-1:2], 2'b00};
            r_state   <= FETCH;
            r_imemReq <= 1'b1;
`endif
          end
        end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        HALT: begin
          r_state      <= HALT;
          r_imemReq    <= 1'b0;
          r_instrValid <= 1'b0;
        end
`endif
        default: begin
          r_state      <= IDLE;
          r_imemReq    <= 1'b0;
          r_instrValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer : directed + randomized bench with an instruction-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

  localparam logic [31:0] c_resetVector = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        BranchEQ, BranchNE, Jump, Jal, JR, Zero;
  logic [31:0] SignExtImm;
  logic [31:0] RegRs;
  logic        stall;
  logic        misalign_err;

  int          checkCount = 0;
  int          failCount  = 0;
  logic [31:0] expPc;
  logic        haltExp;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Instruction (Instruction),
    .instr_valid (instr_valid),
    .PC          (PC),
    .PC_plus4    (PC_plus4),
    .BranchEQ    (BranchEQ),
    .BranchNE    (BranchNE),
    .Jump        (Jump),
    .Jal         (Jal),
    .JR          (JR),
    .Zero        (Zero),
    .SignExtImm  (SignExtImm),
    .RegRs       (RegRs),
    .stall       (stall),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // ctrl = {jr, jump, jal, beq, bne, zero}
  function automatic logic [31:0] refNext(input logic [31:0] pc, input logic [31:0] word,
                                          input logic [5:0] ctrl, input logic [31:0] imm,
                                          input logic [31:0] rs);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (ctrl[5])                                   return rs;
    if (ctrl[4])                                   return {p4[31:28], word[25:0], 2'b00};
    if ((ctrl[2] && ctrl[0]) || (ctrl[1] && !ctrl[0])) return p4 + imm * 32'd4;
    return p4;
  endfunction

  task automatic scrambleCtrl();
    {JR, Jump, Jal, BranchEQ, BranchNE, Zero} = 6'($urandom);
    SignExtImm = $urandom;
    RegRs      = $urandom;
  endtask

  // One instruction: fetch with ackDelay wait cycles, then EXEC held for 'stalls' cycles.
  task automatic runInstr(input int ackDelay, input int stalls, input logic [31:0] word,
                          input logic [5:0] ctrl, input logic [31:0] imm, input logic [31:0] rs);
    logic [31:0] nxt;
    for (int i = 0; i <= ackDelay; i++) begin
      checkVal("fetch_req", {31'd0, imem_req}, 32'd1);
      checkVal("fetch_addr", imem_addr, expPc);
      checkVal("fetch_valid", {31'd0, instr_valid}, 32'd0);
      imem_ack   = (i == ackDelay);
      imem_rdata = (i == ackDelay) ? word : $urandom;
      stall      = 1'($urandom_range(0, 1));
      scrambleCtrl();
      step();
    end
    for (int i = 0; i <= stalls; i++) begin
      checkVal("exec_valid", {31'd0, instr_valid}, 32'd1);
      checkVal("exec_req", {31'd0, imem_req}, 32'd0);
      checkVal("exec_instr", Instruction, word);
      checkVal("exec_pc", PC, expPc);
      checkVal("exec_pc4", PC_plus4, expPc + 32'd4);
      checkVal("exec_misalign", {31'd0, misalign_err}, 32'd0);
      {JR, Jump, Jal, BranchEQ, BranchNE, Zero} = ctrl;
      SignExtImm = imm;
      RegRs      = rs;
      stall      = (i < stalls);
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      step();
    end
    nxt = refNext(expPc, word, ctrl, imm, rs);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    if (nxt[1:0] != 2'b00) haltExp = 1'b1;
    else                   expPc   = nxt;
`else
    expPc = {nxt[31:2], 2'b00};
`endif
    imem_ack = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic nop();
    runInstr(0, 0, 32'h0, 6'b000000, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] word, imm, rs, haltPc;
    logic [5:0]  ctrl;
    reset      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    stall      = 1'b0;
    {JR, Jump, Jal, BranchEQ, BranchNE, Zero} = '0;
    SignExtImm = '0;
    RegRs      = '0;
    haltExp    = 1'b0;
    expPc      = c_resetVector;

    repeat (3) step();
    checkVal("rst_pc", PC, c_resetVector);
    checkVal("rst_instr", Instruction, 32'h0);
    checkVal("rst_req", {31'd0, imem_req}, 32'd0);
    checkVal("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkVal("rst_misalign", {31'd0, misalign_err}, 32'd0);
    reset = 1'b1;
    step();

    // NOP stream, same-cycle ack: 0x00, 0x04, 0x08, 0x0C
    repeat (4) nop();
    checkVal("nop_seq_addr", imem_addr, 32'h0040_0010);
    // BEQ taken back by one word
    runInstr(0, 0, 32'h1000_FFFE, 6'b000101, 32'hFFFF_FFFE, 32'h0);
    checkVal("beq_taken", imem_addr, 32'h0040_000C);
    nop();
    runInstr(0, 0, 32'h1000_FFFE, 6'b000100, 32'hFFFF_FFFE, 32'h0);
    checkVal("beq_not_taken", imem_addr, 32'h0040_0014);
    repeat (3) nop();
    // JAL at 0x20
    runInstr(0, 0, 32'h0C10_0040, 6'b011000, 32'h0, 32'h0);
    checkVal("jal_target", imem_addr, 32'h0040_0100);
    // JR beats Jump
    runInstr(0, 0, 32'h0810_0000, 6'b110000, 32'h0, 32'h0040_0024);
    checkVal("jr_priority", imem_addr, 32'h0040_0024);
    // Ack withheld 3 cycles, then 2 stall cycles
    runInstr(3, 2, 32'h2108_0001, 6'b000000, 32'h0, 32'h0);
    checkVal("stall_advance", imem_addr, 32'h0040_0028);
    // Wrap-around from the top of the address space
    runInstr(1, 0, 32'h0, 6'b100000, 32'h0, 32'hFFFF_FFFC);
    checkVal("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    nop();
    checkVal("wrap_zero", imem_addr, 32'h0000_0000);
`ifndef PC_SEQ_MISALIGN_TRAP_EN
    runInstr(0, 0, 32'h0, 6'b100000, 32'h0, 32'h0040_0002);
    checkVal("misalign_forced", imem_addr, 32'h0040_0000);
`endif

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      word = $urandom;
      ctrl[5] = ($urandom_range(0, 7) == 0);
      ctrl[4] = ($urandom_range(0, 5) == 0);
      ctrl[3] = ctrl[4] & 1'($urandom_range(0, 1));
      ctrl[2] = ($urandom_range(0, 2) == 0);
      ctrl[1] = ($urandom_range(0, 2) == 0);
      ctrl[0] = 1'($urandom_range(0, 1));
      imm     = $urandom;
      imm     = {{20{imm[11]}}, imm[11:0]};
      rs      = $urandom;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      rs[1:0] = 2'b00;
`endif
      runInstr($urandom_range(0, 3), $urandom_range(0, 2), word, ctrl, imm, rs);
    end

    // Reset during FETCH with a pending request; late ack lands in IDLE
    checkVal("pre_rst_req", {31'd0, imem_req}, 32'd1);
    reset    = 1'b0;
    imem_ack = 1'b0;
    step();
    checkVal("midrst_req", {31'd0, imem_req}, 32'd0);
    checkVal("midrst_pc", PC, c_resetVector);
    checkVal("midrst_instr", Instruction, 32'h0);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    checkVal("idle_ack_instr", Instruction, 32'h0);
    checkVal("idle_ack_req", {31'd0, imem_req}, 32'd1);
    checkVal("idle_ack_addr", imem_addr, 32'h0040_0000);
    imem_ack = 1'b0;
    expPc    = c_resetVector;
    nop();

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    haltPc = expPc;
    runInstr(0, 0, 32'h0, 6'b100000, 32'h0, 32'h0040_0002);
    checkVal("halt_expected", {31'd0, haltExp}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkVal("halt_misalign", {31'd0, misalign_err}, 32'd1);
      checkVal("halt_req", {31'd0, imem_req}, 32'd0);
      checkVal("halt_valid", {31'd0, instr_valid}, 32'd0);
      checkVal("halt_pc", PC, haltPc);
      imem_ack = 1'b1;
      stall    = 1'($urandom_range(0, 1));
      scrambleCtrl();
      step();
    end
    imem_ack = 1'b0;
    reset    = 1'b0;
    step();
    checkVal("halt_rst_misalign", {31'd0, misalign_err}, 32'd0);
    reset = 1'b1;
    step();
    checkVal("halt_rst_req", {31'd0, imem_req}, 32'd1);
`else
    haltPc = expPc;
    checkVal("final_addr", imem_addr, haltPc);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

`default_nettype wire
